shinnu_delay_line_controller: RTL and testbench
===============================================

Name: shinnu_delay_line_controller

Overview:
- Digitally controlled tapped delay line for the PRN-based CDR loop.
- Serial data `din` is shifted through a DEPTH-stage register chain every clock.
- `dout` is the stage chosen by a tap pointer.
- Phase-detector decisions `sr`/`sl` move the tap pointer one stage per cycle, adding or removing delay to align the recovered data.

Parameters:
- DEPTH, 16, number of delay stages (≥2).
- INIT_TAP, DEPTH/2, tap pointer value loaded on reset (0..DEPTH-1).
- TAP_W, $clog2(DEPTH), tap pointer width (derived, not overridden).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (rst==0 resets at next rising clk edge).
- sr  input  1  shift-right request: increase delay by one stage.
- sl  input  1  shift-left request: decrease delay by one stage.
- din  input  1  serial data input, sampled every rising edge.
- dout  output  1  delayed data = currently selected delay stage.

Behaviour:
- State: line[DEPTH-1:0] shift register; tap[TAP_W-1:0] pointer.
- Reset (rst==0 at edge): line <= all 0; tap <= INIT_TAP. Reset has priority over all other inputs; sr/sl/din are ignored that cycle.
- Delay line, each non-reset edge: line[0] <= din; line[i] <= line[i-1] for i=1..DEPTH-1.
- Output:
  - dout = line[tap], combinational mux from registered state only; no dependence on current din/sr/sl.
  - dout is 0 while/after reset until data propagates.
  - Total latency from din sampled at edge E to dout is tap+1 edges: dout reflects that bit after edge E+tap.
- Tap control, each non-reset edge, evaluated on pre-edge tap:
  - sr=1, sl=0: tap <= tap+1 if tap<DEPTH-1, else hold (saturate at DEPTH-1).
  - sr=0, sl=1: tap <= tap-1 if tap>0, else hold (saturate at 0).
  - sr=sl=0 or sr=sl=1: hold (conflicting requests cancel).
- Held requests move tap one stage per clock until saturation; no wrap-around ever.
- A tap change takes effect on dout immediately after the edge that updates tap. The delay line itself is not flushed or altered by tap moves, so dout may repeat or skip a bit at the switch.
- Reset mid-operation: next edge with rst==0 clears line and restores INIT_TAP regardless of sr/sl.
- No X propagation after reset: every register has a defined reset value.

Decomposition:
- Shared package cdr_pkg: DEPTH default, INIT_TAP default, and the TAP_W derivation (clog2).
- One natural sub-module: delay_tap_counter, a saturating up/down counter with synchronous active-low reset to INIT_TAP; inputs sr/sl, output tap.
- Shift register and output mux remain in the top.

Test Plan:
- Reset: hold rst=0 for 2 edges with din=1, sr=1 -> after release, tap==8, line==0, dout=0 (DEPTH=16, INIT_TAP=8).
- Fixed-delay pulse: sr=sl=0, single din=1 sampled at edge E -> dout=1 exactly after edge E+8 for one cycle, 0 otherwise.
- Delay-length pattern: din sequence 0,0,0,1,1,0,0,0,0,1,1,0,0,1,0,1,0,0,0,1 -> dout reproduces the identical sequence shifted by 9 cycles.
- Shift-left saturation: sl=1 held 12 cycles from tap=8 -> tap decrements 8..0 over 8 edges then holds 0; dout then equals din delayed by 1 edge.
- Shift-right saturation: sr=1 held 10 cycles from tap=8 -> tap reaches 15 after 7 edges and holds; pulse latency becomes 16 edges.
- Conflict and mid-run reset: sr=sl=1 for 5 cycles -> tap unchanged. Then rst=0 for one edge while tap=3 and line non-zero -> tap==8, dout=0 next cycle.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared CDR delay-line definitions: default geometry, tap-width derivation
// and the decoded phase-detector command used by the tap counter.
package cdr_pkg;

  localparam int DEPTH_DEFAULT    = 16;
  localparam int INIT_TAP_DEFAULT = DEPTH_DEFAULT / 2;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_UP   = 2'b01,
    CMD_DOWN = 2'b10
  } tap_cmd_e;

  function automatic int tap_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Conflicting or absent requests both collapse to HOLD.
  function automatic tap_cmd_e decode_cmd(input logic sr, input logic sl);
    tap_cmd_e cmd;
    case ({sr, sl})
      2'b10:   cmd = CMD_UP;
      2'b01:   cmd = CMD_DOWN;
      default: cmd = CMD_HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/delay_tap_counter.sv
// Saturating up/down tap pointer for the delay line; moves one stage per
// clock on sr/sl and never wraps.
module delay_tap_counter
  import cdr_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int INIT_TAP = INIT_TAP_DEFAULT,
  parameter int TAP_W    = tap_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sr,
  input  logic             sl,
  output logic [TAP_W-1:0] tap
);

  localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(DEPTH - 1);
  localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] TAP_ZERO = TAP_W'(0);
  localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);

  tap_cmd_e         cmd_s;
  logic [TAP_W-1:0] tap_d;
  logic [TAP_W-1:0] tap_q;

  always_comb begin
    cmd_s = decode_cmd(sr, sl);
    tap_d = tap_q;
    case (cmd_s)
      CMD_UP: begin
        if (tap_q < TAP_MAX) tap_d = tap_q + TAP_ONE;
        else                 tap_d = tap_q;
      end
      CMD_DOWN: begin
        if (tap_q > TAP_ZERO) tap_d = tap_q - TAP_ONE;
        else                  tap_d = tap_q;
      end
      default: tap_d = tap_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) tap_q <= TAP_INIT;
    else      tap_q <= tap_d;
  end

  assign tap = tap_q;

endmodule

// File: rtl/shinnu_delay_line_controller.sv
// Tapped delay line for the PRN CDR loop: din shifts through DEPTH stages and
// dout selects the stage addressed by the phase-detector-steered tap pointer.
module shinnu_delay_line_controller
  import cdr_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int INIT_TAP = DEPTH / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sr,
  input  logic sl,
  input  logic din,
  output logic dout
);

  localparam int TAP_W = tap_width(DEPTH);

  logic [DEPTH-1:0] line_d;
  logic [DEPTH-1:0] line_q;
  logic [TAP_W-1:0] tap;

  delay_tap_counter #(
    .DEPTH    (DEPTH),
    .INIT_TAP (INIT_TAP),
    .TAP_W    (TAP_W)
  ) u_tap (
    .clk (clk),
    .rst (rst),
    .sr  (sr),
    .sl  (sl),
    .tap (tap)
  );

  always_comb begin
    line_d = {line_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (!rst) line_q <= {DEPTH{1'b0}};
    else      line_q <= line_d;
  end

  // Tap moves are not flushed through the line, so dout may repeat or skip a bit.
  assign dout = line_q[tap];

endmodule

// File: tb/tb_shinnu_delay_line_controller.sv
// Directed bench for the tapped delay line: a spec-level model pushes the
// expected dout per edge into a queue that is popped and compared after the edge.
module tb_shinnu_delay_line_controller;

  localparam int DEPTH = 16;
  localparam int INIT  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sr  = 1'b0;
  logic sl  = 1'b0;
  logic din = 1'b0;
  logic dout;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_q[$];
  logic [DEPTH-1:0] hist_m = '0;
  int   tap_m = INIT;

  shinnu_delay_line_controller #(.DEPTH(DEPTH), .INIT_TAP(INIT)) dut (
    .clk  (clk),
    .rst  (rst),
    .sr   (sr),
    .sl   (sl),
    .din  (din),
    .dout (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, model the edge, compare dout after it.
  task automatic step(input logic d, input logic r, input logic l, input logic rs);
    logic e;
    @(negedge clk);
    din = d; sr = r; sl = l; rst = rs;
    if (!rs) begin
      hist_m = '0;
      tap_m  = INIT;
    end else begin
      hist_m = {hist_m[DEPTH-2:0], d};
      if (r && !l && tap_m < DEPTH - 1)      tap_m = tap_m + 1;
      else if (l && !r && tap_m > 0)         tap_m = tap_m - 1;
    end
    exp_q.push_back(hist_m[tap_m]);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_assert++;
    assert (dout === e) else begin
      n_fail++;
      $error("FAIL dout: observed=%b expected=%b (tap_model=%0d)", dout, e, tap_m);
    end
  endtask

  // Flush with zeros, then count edges from the sampled 1 until dout shows it.
  task automatic latency(input string tag, input int exp);
    int cnt;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    cnt = 1;
    while (dout !== 1'b1 && cnt < 40) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      cnt++;
    end
    check(tag, cnt, exp);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check({tag, "_single"}, int'(dout), 0);
  endtask

  initial begin
    logic [19:0] pat;
    pat = 20'b0001_1000_0110_0101_0001;

    // Reset held two edges with din=1, sr=1.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_tap",  int'(dut.u_tap.tap_q), INIT);
    check("reset_line", int'(dut.line_q), 0);
    check("reset_dout", int'(dout), 0);

    // Fixed delay at INIT tap: din at edge E appears after edge E+8.
    latency("latency_tap8", INIT + 1);

    // Pattern reproduced with 9-edge latency (model scoreboard per edge).
    for (int i = 19; i >= 0; i--) step(pat[i], 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)  step(1'b0, 1'b0, 1'b0, 1'b1);

    // Shift-left saturation from 8.
    for (int i = 0; i < 12; i++) begin
      step(1'($urandom_range(1)), 1'b0, 1'b1, 1'b1);
      check("sl_tap", int'(dut.u_tap.tap_q), (INIT - i - 1 > 0) ? INIT - i - 1 : 0);
    end
    latency("latency_tap0", 1);
    for (int i = 0; i < 8; i++) step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b1);

    // Back to INIT, then shift-right saturation.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst2_tap", int'(dut.u_tap.tap_q), INIT);
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(1)), 1'b1, 1'b0, 1'b1);
      check("sr_tap", int'(dut.u_tap.tap_q), (INIT + i + 1 < DEPTH - 1) ? INIT + i + 1 : DEPTH - 1);
    end
    latency("latency_tap15", DEPTH);

    // Conflicting requests cancel.
    for (int i = 0; i < 5; i++) step(1'($urandom_range(1)), 1'b1, 1'b1, 1'b1);
    check("conflict_tap", int'(dut.u_tap.tap_q), DEPTH - 1);

    // Move to tap 3, fill line, then a single mid-run reset edge.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    check("tap3", int'(dut.u_tap.tap_q), 3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("line_nonzero", int'(dut.line_q != '0), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("midrst_tap",  int'(dut.u_tap.tap_q), INIT);
    check("midrst_line", int'(dut.line_q), 0);
    check("midrst_dout", int'(dout), 0);
    for (int i = 0; i < 12; i++) step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
